// File: rtl/vend_pkg.sv
// Shared types and constants for the vending front end and vending FSM.
package vend_pkg;

    typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} deb_state_t;

    localparam int NICKEL_CENTS = 5;
    localparam int DIME_CENTS   = 10;

endpackage

// File: rtl/coin_debounce.sv
// One coin sensor channel: 2-flop synchronizer, debounce FSM and
// a registered one-cycle event on each accepted insertion.
module coin_debounce
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    deb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        unique case (state_q)
            S_LOW: begin
                if (sync2_q) begin
                    cnt_d   = '0;
                    state_d = S_RISE;
                end
            end
            S_RISE: begin
                if (sync2_q) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == LAST) begin
                        state_d = S_HIGH;
                        rise_d  = 1'b1;
                    end
                end else begin
                    state_d = S_LOW;
                end
            end
            S_HIGH: begin
                if (!sync2_q) begin
                    cnt_d   = '0;
                    state_d = S_FALL;
                end
            end
            S_FALL: begin
                if (!sync2_q) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == LAST) begin
                        state_d = S_LOW;
                    end
                end else begin
                    state_d = S_HIGH;
                end
            end
            default: state_d = S_LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= S_LOW;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    assign stable = (state_q == S_HIGH) || (state_q == S_FALL);
    assign rise   = rise_q;

endmodule

// File: rtl/coin_pulse_conditioner.sv
// Coin front end: debounced nickel/dime channels, one-credit-per-cycle
// arbitration, door-open lockout with saturating reject counter.
module coin_pulse_conditioner
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REJ_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             nickel_raw,
    input  logic             dime_raw,
    input  logic             vend_open,
    output logic             N,
    output logic             D,
    output logic             coin_return,
    output logic [REJ_W-1:0] reject_count
);

    localparam int SW = REJ_W + 2;

    logic n_ev, d_ev;
    logic n_stable, d_stable;
    logic unused;

    logic             n_q, n_d;
    logic             d_q, d_d;
    logic             ret_q, ret_d;
    logic [REJ_W-1:0] rej_q, rej_d;
    logic             pend_d_q, pend_d_d;
    logic             pend_n_q, pend_n_d;
    logic [2:0]       nrej;
    logic [SW-1:0]    sum;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel (
        .clk    (clk),
        .rst    (rst),
        .raw    (nickel_raw),
        .stable (n_stable),
        .rise   (n_ev)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime (
        .clk    (clk),
        .rst    (rst),
        .raw    (dime_raw),
        .stable (d_stable),
        .rise   (d_ev)
    );

    assign unused = &{1'b0, n_stable, d_stable};

    // Door open refuses every coin available this cycle at once.
    always_comb begin
        n_d      = 1'b0;
        d_d      = 1'b0;
        ret_d    = 1'b0;
        pend_d_d = 1'b0;
        pend_n_d = 1'b0;
        nrej     = '0;
        if (vend_open) begin
            nrej  = 3'(pend_d_q) + 3'(pend_n_q) + 3'(n_ev) + 3'(d_ev);
            ret_d = |nrej;
        end else if (pend_d_q) begin
            d_d      = 1'b1;
            pend_n_d = n_ev;
        end else if (pend_n_q) begin
            n_d      = 1'b1;
            pend_d_d = d_ev;
        end else if (n_ev) begin
            n_d      = 1'b1;
            pend_d_d = d_ev;
        end else begin
            d_d = d_ev;
        end
        sum = {2'b00, rej_q} + SW'(nrej);
        if (sum[SW-1:REJ_W] != 2'b00) begin
            rej_d = '1;
        end else begin
            rej_d = sum[REJ_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q      <= 1'b0;
            d_q      <= 1'b0;
            ret_q    <= 1'b0;
            rej_q    <= '0;
            pend_d_q <= 1'b0;
            pend_n_q <= 1'b0;
        end else begin
            n_q      <= n_d;
            d_q      <= d_d;
            ret_q    <= ret_d;
            rej_q    <= rej_d;
            pend_d_q <= pend_d_d;
            pend_n_q <= pend_n_d;
        end
    end

    assign N            = n_q;
    assign D            = d_q;
    assign coin_return  = ret_q;
    assign reject_count = rej_q;

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// Bench for coin_pulse_conditioner: directed scenarios plus random
// bouncing inputs, checked every cycle against a queue-based model.
module tb_coin_pulse_conditioner;

    localparam int DEB = 4;
    localparam int REJ_MAX = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       nickel_raw = 1'b0;
    logic       dime_raw = 1'b0;
    logic       vend_open = 1'b0;
    logic       N, D, coin_return;
    logic [7:0] reject_count;

    coin_pulse_conditioner #(.DEBOUNCE_CYCLES(DEB), .REJ_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .nickel_raw   (nickel_raw),
        .dime_raw     (dime_raw),
        .vend_open    (vend_open),
        .N            (N),
        .D            (D),
        .coin_return  (coin_return),
        .reject_count (reject_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    // model state: per channel [0]=nickel [1]=dime
    logic s1 [2];
    logic s2 [2];
    logic lvl [2];
    int   run [2];
    logic ev [2];
    int   q [$];
    int   e_rej;
    logic e_n, e_d, e_r;

    int cn, cd, cr;
    int t_n, t_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model(input logic nr, input logic dr, input logic vo, input logic r);
        logic raw [2];
        logic in;
        raw[0] = nr;
        raw[1] = dr;
        e_n = 0;
        e_d = 0;
        e_r = 0;
        if (r) begin
            for (int c = 0; c < 2; c++) begin
                s1[c] = 0; s2[c] = 0; lvl[c] = 0; run[c] = 0; ev[c] = 0;
            end
            q.delete();
            e_rej = 0;
            return;
        end
        if (ev[0]) q.push_back(0);
        if (ev[1]) q.push_back(1);
        if (vo) begin
            e_r = (q.size() > 0);
            e_rej = e_rej + q.size();
            if (e_rej > REJ_MAX) e_rej = REJ_MAX;
            q.delete();
        end else if (q.size() > 0) begin
            if (q.pop_front() == 0) e_n = 1;
            else e_d = 1;
        end
        for (int c = 0; c < 2; c++) begin
            in = s2[c];
            s2[c] = s1[c];
            s1[c] = raw[c];
            ev[c] = 0;
            if (in != lvl[c]) run[c]++;
            else run[c] = 0;
            if (run[c] == DEB) begin
                lvl[c] = in;
                run[c] = 0;
                ev[c] = in;
            end
        end
    endtask

    task automatic step(input logic nr, input logic dr, input logic vo, input logic r);
        nickel_raw = nr;
        dime_raw = dr;
        vend_open = vo;
        rst = r;
        @(posedge clk);
        model(nr, dr, vo, r);
        #1;
        chk("N", N, e_n);
        chk("D", D, e_d);
        chk("coin_return", coin_return, e_r);
        chk("reject_count", reject_count, e_rej);
        chk("exclusive", N & D, 0);
        cn += N;
        cd += D;
        cr += coin_return;
        @(negedge clk);
    endtask

    task automatic clr();
        cn = 0; cd = 0; cr = 0; t_n = -1; t_d = -1;
    endtask

    initial begin
        int hn, hd, hv;
        logic rn, rd, rv;

        // reset
        clr();
        repeat (3) step(0, 0, 0, 1);
        chk("reset_N", N, 0);
        chk("reset_rej", reject_count, 0);
        repeat (2) step(0, 0, 0, 0);

        // 1: nickel held 20 cycles, pulse on 7th edge
        clr();
        for (int i = 1; i <= 20; i++) begin
            step(1, 0, 0, 0);
            if (N && t_n < 0) t_n = i;
        end
        repeat (10) step(0, 0, 0, 0);
        chk("t1_latency", t_n, DEB + 3);
        chk("t1_n_count", cn, 1);
        chk("t1_d_count", cd, 0);

        // 2: toggling nickel produces nothing
        clr();
        for (int i = 0; i < 10; i++) step(i[0], 0, 0, 0);
        repeat (12) step(0, 0, 0, 0);
        chk("t2_n", cn, 0);
        chk("t2_d", cd, 0);
        chk("t2_ret", cr, 0);

        // 3: simultaneous insertion
        clr();
        for (int i = 1; i <= 15; i++) begin
            step(1, 1, 0, 0);
            if (N && t_n < 0) t_n = i;
            if (D && t_d < 0) t_d = i;
        end
        repeat (10) step(0, 0, 0, 0);
        chk("t3_n_time", t_n, DEB + 3);
        chk("t3_d_time", t_d, DEB + 4);

        // 4: lockout, then saturation
        clr();
        repeat (2) step(0, 0, 1, 1);
        repeat (6) step(0, 1, 1, 0);
        repeat (8) step(0, 0, 1, 0);
        chk("t4_d", cd, 0);
        chk("t4_ret", cr, 1);
        chk("t4_rej1", reject_count, 1);
        for (int k = 0; k < 299; k++) begin
            repeat (6) step(0, 1, 1, 0);
            repeat (8) step(0, 0, 1, 0);
        end
        chk("t4_sat", reject_count, 255);
        chk("t4_ret_total", cr, 300);

        // 5: pending dime meets door opening
        clr();
        repeat (2) step(0, 0, 0, 1);
        for (int i = 1; i <= 16; i++) step(1, 1, (i >= DEB + 4), 0);
        repeat (10) step(0, 0, 1, 0);
        chk("t5_n", cn, 1);
        chk("t5_d", cd, 0);
        chk("t5_ret", cr, 1);
        chk("t5_rej", reject_count, 1);

        // 6: reset mid-debounce
        clr();
        repeat (DEB + 1) step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("t6_N", N, 0);
        chk("t6_D", D, 0);
        chk("t6_ret", coin_return, 0);
        repeat (15) step(0, 0, 0, 0);
        chk("t6_late_n", cn, 0);

        // random bouncing inputs with door toggling
        hn = 0; hd = 0; hv = 0;
        rn = 0; rd = 0; rv = 0;
        for (int i = 0; i < 2000; i++) begin
            if (hn == 0) begin rn = 1'($urandom_range(0, 1)); hn = $urandom_range(1, 10); end
            if (hd == 0) begin rd = 1'($urandom_range(0, 1)); hd = $urandom_range(1, 10); end
            if (hv == 0) begin rv = 1'($urandom_range(0, 1)); hv = $urandom_range(1, 40); end
            hn--; hd--; hv--;
            step(rn, rd, rv, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
